// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit map, word types and syndrome function.
// Used by both the encoder and the decoder so the bit map has a single source.
package hamming_pkg;

    localparam int unsigned CODE_W = 7;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned SYN_W  = 3;

    localparam int unsigned P1_IDX = 0;
    localparam int unsigned P2_IDX = 1;
    localparam int unsigned D0_IDX = 2;
    localparam int unsigned P4_IDX = 3;
    localparam int unsigned D1_IDX = 4;
    localparam int unsigned D2_IDX = 5;
    localparam int unsigned D3_IDX = 6;

    typedef logic [CODE_W-1:0] codeword_t;
    typedef logic [DATA_W-1:0] dataword_t;
    typedef logic [SYN_W-1:0]  syndrome_t;

    // {s4,s2,s1}; a non-zero value names the erroneous bit index S-1
    function automatic syndrome_t calc_syndrome(input codeword_t c);
        logic s1;
        logic s2;
        logic s4;
        s1 = c[P1_IDX] ^ c[D0_IDX] ^ c[D1_IDX] ^ c[D3_IDX];
        s2 = c[P2_IDX] ^ c[D0_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
        s4 = c[P4_IDX] ^ c[D1_IDX] ^ c[D2_IDX] ^ c[D3_IDX];
        return {s4, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_syndrome_correct.sv
// Combinational single-error correction of one Hamming(7,4) codeword.
// Double-bit errors are miscorrected by design (SEC-only code).
module hamming_syndrome_correct
    import hamming_pkg::*;
(
    input  codeword_t code_i,
    output dataword_t data_o,
    output syndrome_t syn_o,
    output logic      err_o
);

    syndrome_t syn;
    codeword_t flip_mask;
    codeword_t fixed;

    always_comb begin
        syn       = calc_syndrome(code_i);
        flip_mask = '0;
        if (syn != '0) begin
            flip_mask = codeword_t'(1) << (syn - SYN_W'(1));
        end
        fixed  = code_i ^ flip_mask;
        data_o = {fixed[D3_IDX], fixed[D2_IDX], fixed[D1_IDX], fixed[D0_IDX]};
        syn_o  = syn;
        err_o  = (syn != '0);
    end

endmodule

// File: rtl/hamming_decoder_pipe.sv
// Hamming(7,4) receive decoder: input stage, corrected-word output stage with
// valid/ready backpressure, and a saturating count of corrected words delivered.
module hamming_decoder_pipe
    import hamming_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [SYN_W-1:0]  syndrome_out,
    output logic              err_corr,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  corr_count
);

    logic      s1_valid_q, s1_valid_d;
    codeword_t s1_code_q,  s1_code_d;
    logic      s2_valid_q, s2_valid_d;
    dataword_t s2_data_q,  s2_data_d;
    syndrome_t s2_syn_q,   s2_syn_d;
    logic      s2_err_q,   s2_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    dataword_t corr_data;
    syndrome_t corr_syn;
    logic      corr_err;

    logic s2_take;
    logic accept;
    logic s1_adv;

    hamming_syndrome_correct u_corr (
        .code_i (s1_code_q),
        .data_o (corr_data),
        .syn_o  (corr_syn),
        .err_o  (corr_err)
    );

    // Ready depends on out_ready and held state only, never on in_valid
    assign s2_take  = !s2_valid_q || out_ready;
    assign in_ready = rst_n && (!s1_valid_q || s2_take);
    assign accept   = in_valid && in_ready;
    assign s1_adv   = s1_valid_q && s2_take;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_syn_d   = s2_syn_q;
        s2_err_d   = s2_err_q;
        cnt_d      = cnt_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = code_in;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
            s1_code_d  = '0;
        end

        if (s1_adv) begin
            s2_valid_d = 1'b1;
            s2_data_d  = corr_data;
            s2_syn_d   = corr_syn;
            s2_err_d   = corr_err;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
            s2_data_d  = '0;
            s2_syn_d   = '0;
            s2_err_d   = 1'b0;
        end

        // Clear wins over a same-cycle increment; count sticks at all-ones
        if (clr_count) begin
            cnt_d = '0;
        end else if (s2_valid_q && out_ready && s2_err_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_syn_q   <= '0;
            s2_err_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_syn_q   <= s2_syn_d;
            s2_err_q   <= s2_err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign data_out     = s2_data_q;
    assign syndrome_out = s2_syn_q;
    assign err_corr     = s2_err_q;
    assign corr_count   = cnt_q;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Bench for hamming_decoder_pipe: nearest-codeword reference model, in-order
// scoreboard, hold/ready/counter checks each cycle, directed and random traffic.
module tb_hamming_decoder_pipe;

    localparam int unsigned CNT_W   = 2;
    localparam int unsigned CNT_MAX = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       code_in;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       data_out;
    logic [2:0]       syndrome_out;
    logic             err_corr;
    logic             out_valid;
    logic             out_ready;
    logic             clr_count;
    logic [CNT_W-1:0] corr_count;

    always #5 clk = ~clk;

    hamming_decoder_pipe #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .code_in      (code_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_out     (data_out),
        .syndrome_out (syndrome_out),
        .err_corr     (err_corr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .clr_count    (clr_count),
        .corr_count   (corr_count)
    );

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_out    = 0;
    int unsigned m_cnt    = 0;
    logic        mon_en   = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[3] = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    // Perfect code: every 7-bit word lies within distance 1 of exactly one codeword
    function automatic exp_t model(input logic [6:0] c);
        exp_t r = '0;
        for (int d = 0; d < 16; d++) begin
            logic [6:0] diff;
            diff = encode(4'(d)) ^ c;
            if ($countones(diff) <= 1) begin
                r.data = 4'(d);
                r.err  = (diff != 7'd0);
                r.syn  = 3'd0;
                for (int k = 0; k < 7; k++) begin
                    if (diff[k]) r.syn = 3'(k + 1);
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            check("corr_count", 32'(corr_count), 32'(m_cnt));
            check("in_ready", 32'(in_ready), 32'(rst_n && ((q.size() < 2) || out_ready)));
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_payload", 32'({data_out, syndrome_out, err_corr}), 32'(held));
            end
            if (!rst_n) begin
                q.delete();
                m_cnt     = 0;
                hold_prev = 1'b0;
            end else begin
                e = '0;
                if (out_valid) check("out_has_item", 32'(q.size() > 0), 32'd1);
                if (out_valid && out_ready && (q.size() > 0)) begin
                    e = q.pop_front();
                    n_out++;
                    check("data_out", 32'(data_out), 32'(e.data));
                    check("syndrome_out", 32'(syndrome_out), 32'(e.syn));
                    check("err_corr", 32'(err_corr), 32'(e.err));
                end
                if (clr_count) m_cnt = 0;
                else if (out_valid && out_ready && e.err && (m_cnt < CNT_MAX)) m_cnt++;
                hold_prev = out_valid && !out_ready;
                held      = {data_out, syndrome_out, err_corr};
                if (in_valid && in_ready) q.push_back(model(code_in));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [6:0] c, input logic [3:0] d,
                            input logic [2:0] s, input logic e);
        code_in   = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check({name, "_lat1_valid"}, 32'(out_valid), 32'd0);
        cyc();
        check({name, "_lat2_valid"}, 32'(out_valid), 32'd1);
        check({name, "_data"}, 32'(data_out), 32'(d));
        check({name, "_syn"}, 32'(syndrome_out), 32'(s));
        check({name, "_err"}, 32'(err_corr), 32'(e));
        cyc();
    endtask

    // One cycle of stimulus honouring the handshake: a word is held until accepted
    task automatic drive_cycle(input logic want, input logic [6:0] new_code,
                               input logic ordy, input logic clr, output logic acc);
        if (!in_valid) begin
            in_valid = want;
            code_in  = new_code;
        end
        out_ready = ordy;
        clr_count = clr;
        #1;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (acc) in_valid = 1'b0;
        clr_count = 1'b0;
    endtask

    initial begin
        int   out_before;
        int   sent;
        int   cyc_n;
        logic acc;
        logic saw_stall;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        code_in   = 7'd0;
        out_ready = 1'b1;
        clr_count = 1'b0;

        check("model_55", 32'(model(7'h55)), 32'({4'hB, 3'd0, 1'b0}));
        check("model_45", 32'(model(7'h45)), 32'({4'hB, 3'd5, 1'b1}));
        check("model_54", 32'(model(7'h54)), 32'({4'hB, 3'd1, 1'b1}));

        cyc();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        cyc();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        check("rst_syn", 32'(syndrome_out), 32'd0);
        check("rst_err", 32'(err_corr), 32'd0);
        check("rst_count", 32'(corr_count), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        cyc();

        directed("clean", 7'h55, 4'hB, 3'd0, 1'b0);
        check("clean_count", 32'(corr_count), 32'd0);
        directed("data_err", 7'h45, 4'hB, 3'd5, 1'b1);
        check("data_err_count", 32'(corr_count), 32'd1);
        directed("par_err", 7'h54, 4'hB, 3'd1, 1'b1);
        check("par_err_count", 32'(corr_count), 32'd2);

        // All data words, clean and each single-bit flip, back-to-back
        out_before = n_out;
        out_ready  = 1'b1;
        for (int d = 0; d < 16; d++) begin
            for (int k = 0; k < 8; k++) begin
                logic [6:0] flip;
                flip     = (k == 0) ? 7'd0 : (7'd1 << (k - 1));
                code_in  = encode(4'(d)) ^ flip;
                in_valid = 1'b1;
                cyc();
            end
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        check("exhaustive_outputs", 32'(n_out - out_before), 32'd128);

        clr_count = 1'b1;
        cyc();
        clr_count = 1'b0;
        check("clr_count", 32'(corr_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            code_in  = encode(4'(i)) ^ 7'h40;
            in_valid = 1'b1;
            cyc();
        end
        in_valid = 1'b0;
        repeat (3) cyc();
        check("saturate", 32'(corr_count), 32'(CNT_MAX));

        // Clear in the same cycle as a corrected-word handshake
        code_in  = 7'h45;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("clr_hs_valid", 32'(out_valid), 32'd1);
        clr_count = 1'b1;
        cyc();
        clr_count = 1'b0;
        check("clr_priority", 32'(corr_count), 32'd0);

        // Backpressure: out_ready low for 5 cycles mid-stream
        out_before = n_out;
        sent       = 0;
        cyc_n      = 0;
        saw_stall  = 1'b0;
        while ((sent < 10) && (cyc_n < 100)) begin
            drive_cycle(1'b1, 7'($urandom), !((cyc_n >= 3) && (cyc_n < 8)), 1'b0, acc);
            if (acc) sent++;
            else saw_stall = 1'b1;
            cyc_n++;
        end
        check("bp_all_sent", 32'(sent), 32'd10);
        check("bp_saw_stall", 32'(saw_stall), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("bp_outputs", 32'(n_out - out_before), 32'd10);

        // Random traffic including double-bit errors
        for (int i = 0; i < 800; i++) begin
            drive_cycle(($urandom % 4) != 0, 7'($urandom), ($urandom % 3) != 0,
                        ($urandom % 16) == 0, acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("rand_drained", 32'(q.size()), 32'd0);

        // Reset with both stages full and a non-zero count
        code_in  = 7'h54;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (3) cyc();
        check("pre_rst_count_nz", 32'(corr_count != '0), 32'd1);
        out_ready = 1'b0;
        code_in   = 7'h45;
        in_valid  = 1'b1;
        cyc();
        code_in = 7'h55;
        cyc();
        in_valid = 1'b0;
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        cyc();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(corr_count), 32'd0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) cyc();
        check("post_rst_no_output", 32'(out_valid), 32'd0);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hamming_decoder_pipe.md
Name: hamming_decoder_pipe

Overview:
- Receive-side Hamming(7,4) decoder; the stage directly downstream of the team's Hamming(7,4) encoder.
- Accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome.
- Corrects any single-bit error and delivers the 4-bit data word through a 2-stage registered pipeline with backpressure.
- Keeps a saturating count of corrected words for the status logic.

Parameters:
- CNT_W, 8, width of the corrected-word counter (saturating).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- code_in  in  7  codeword. Bit map: [0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3.
- in_valid  in  1  code_in is valid this cycle.
- in_ready  out  1  block accepts code_in this cycle.
- data_out  out  4  decoded and corrected data {d3,d2,d1,d0}.
- syndrome_out  out  3  syndrome {s4,s2,s1} of the word presented.
- err_corr  out  1  presented word had a non-zero syndrome and was corrected.
- out_valid  out  1  data_out, syndrome_out and err_corr are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- clr_count  in  1  synchronous clear of corr_count.
- corr_count  out  CNT_W  number of corrected words delivered, saturating.

Behaviour:
- Reset (rst_n=0 at a clock edge): s1_valid=0, s2_valid=0, out_valid=0, data_out=0, syndrome_out=0, err_corr=0, corr_count=0. in_ready is 0 during reset.
- Syndrome, computed from the codeword c:
  - s1 = c0^c2^c4^c6
  - s2 = c1^c2^c5^c6
  - s4 = c3^c4^c5^c6
  - The value S = {s4,s2,s1} (1..7) names the erroneous bit index S-1.
- Stage 1 (S1): registers code_in and its syndrome. Loads when in_valid && in_ready.
- Stage 2 (S2): registers the corrected word.
  - If S != 0, flip bit S-1; otherwise pass the codeword through.
  - Then extract data_out = {c6,c5,c4,c2} and set err_corr = (S != 0).
  - S2 loads from S1 when s1_valid && s2_take.
- Handshake:
  - s2_take = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_take. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - out_valid = s2_valid.
  - Outputs hold stable while out_valid && !out_ready.
- Latency: exactly 2 cycles from acceptance to out_valid when out_ready is held high. Throughput: 1 word per cycle.
- Stage clears: S1 clears when it advances with no new input; S2 clears when out_ready && !s1_valid.
- Errors: double-bit errors are miscorrected (a SEC-only code). This is required behaviour, not detected.
- corr_count:
  - Increments by 1 on out_valid && out_ready && err_corr.
  - Saturates at 2^CNT_W-1 and never wraps.
  - clr_count has priority over a same-cycle increment; the result is 0.
- Reset mid-stream: all in-flight words are discarded, no output is produced for them, and the counter is zeroed.
- No data loss or duplication under any in_valid/out_ready pattern.

Decomposition:
- Shared package hamming_pkg, holding:
  - localparams CODE_W=7, DATA_W=4;
  - bit-position constants P1_IDX, P2_IDX, D0_IDX, P4_IDX, D1_IDX, D2_IDX, D3_IDX;
  - typedef logic [6:0] codeword_t, logic [3:0] dataword_t, logic [2:0] syndrome_t;
  - a function calc_syndrome(codeword_t).
- The encoder uses the same package so that the bit map is single-sourced.
- One sub-module, hamming_syndrome_correct: a combinational block taking codeword_t and returning corrected dataword_t, syndrome_t and an error flag.
- The pipeline, handshake and counter stay in the top module.

Test Plan:
- Clean word: code_in=7'h55 with out_ready=1 -> 2 cycles later data_out=4'hB, syndrome_out=3'd0, err_corr=0; corr_count stays 0.
- Data-bit error: code_in=7'h45 (bit 4 flipped) -> data_out=4'hB, syndrome_out=3'd5, err_corr=1; corr_count=1 after the handshake.
- Parity-bit error: code_in=7'h54 (bit 0 flipped) -> data_out=4'hB, syndrome_out=3'd1, err_corr=1.
- Exhaustive single-bit errors: all 16 data words × 8 cases (clean + 7 flips) streamed back-to-back -> every data_out matches its source, in order.
- Backpressure: stream 10 words with out_ready held low for 5 cycles mid-stream -> in_ready drops after 2 words are buffered, outputs hold stable, no loss or duplication, order preserved.
- Counter edges, with CNT_W=2:
  - 5 corrected words -> corr_count saturates at 3;
  - clr_count asserted in the same cycle as a corrected-word handshake -> corr_count=0;
  - rst_n=0 with S1/S2 full -> out_valid=0 on the next cycle and corr_count=0.
